mmio_responder: RTL and testbench
=================================

Name: mmio_responder

Overview:
- Memory-mapped I/O responder on the SoC data bus: answers the same ADDR/WDATA/WMASK/rdata interface that the RAM answers, from the bus-responder side.
- Holds the LED output register, synchronised and debounced button inputs with sticky press capture, and an optional free-running timer with compare.
- Sits beside RAM; the SoC steers rdata through a mux on `hit`.

Parameters:
- BASE_ADDR, 32'h0000_2000, base of the 256-byte register window; only ADDR[31:8] is compared.
- DEBOUNCE_CYCLES, 4, number of stable clk cycles required before a button level is accepted; legal range 1..255.
- NUM_LEDS, 5, width of the LED register; legal range 1..32.

Ports:
- CLK  input  1  bus/system clock, the Clockworks divided clock.
- RESETN  input  1  asynchronous active-low reset.
- ADDR  input  32  byte address from the CPU.
- WDATA  input  32  write data.
- WMASK  input  5  write-size code: 00111 = byte, 01111 = half, 11111 = word; a write requires bit 0 set.
- BUTTONS  input  3  raw asynchronous button levels.
- rdata  output  32  registered read data.
- hit  output  1  combinational decode: ADDR[31:8] == BASE_ADDR[31:8].
- leds  output  NUM_LEDS  LED register contents.
- irq  output  1  timer compare flag; driven only when MMIO_TIMER_EN is defined.

Behaviour:
- Reset:
  - Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RESETN.
  - Reset values: rdata=0, leds=0, irq=0, sync/debounce state=0, BTN_EDGE=0, TIMER=0, TIMER_CMP=32'hFFFF_FFFF, STATUS=0.
  - Reset asserted mid-write discards that write.
- Register map, word offset = ADDR[7:2]:
  - 0x00 LED, RW; bits [NUM_LEDS-1:0], upper bits read 0.
  - 0x04 BTN, RO; debounced levels in [2:0].
  - 0x08 BTN_EDGE, RW1C; sticky rising-edge flags in [2:0].
  - 0x0C TIMER, RW.
  - 0x10 TIMER_CMP, RW.
  - 0x14 STATUS, W1C; bit0 = compare match.
  - Any other offset reads 0 and ignores writes.
- Read:
  - Every posedge CLK, rdata <= selected register, or 0 when !hit. One-cycle latency, matching RAM.
  - ADDR[1:0] is ignored.
- Write:
  - Occurs on a posedge with hit && WMASK[0].
  - 00111 replaces bits [7:0]; 01111 replaces bits [15:0]; 11111 replaces all 32 bits.
  - Any other code with bit 0 set is ignored.
  - A read in the same cycle returns the pre-write value.
- Buttons:
  - Each button passes through a 2-flop synchroniser, then a per-button counter.
  - The debounced level changes only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any return to the current level clears the counter.
  - A debounced 0->1 transition sets the matching BTN_EDGE bit.
  - W1C on the same cycle as a new edge: the edge wins and the bit stays 1.
- Timer (MMIO_TIMER_EN only):
  - TIMER increments by 1 every cycle and wraps FFFF_FFFF->0.
  - On a write cycle TIMER takes the merged written value and does not increment.
  - When TIMER == TIMER_CMP, STATUS[0] is set the following cycle.
  - A set condition and a W1C on the same cycle leave the bit set.
  - irq = STATUS[0], registered.

Optional Feature:
- Macro MMIO_TIMER_EN.
- Defined: TIMER, TIMER_CMP, STATUS and irq are implemented as above.
- Undefined: offsets 0x0C, 0x10 and 0x14 read 0 and ignore writes, no timer flops are generated, and irq is tied to 0.

Test Plan:
- Word write 32'hFFFF_FFFF to BASE+0x00 with WMASK=11111 -> leds=5'b11111; read of BASE+0x00 -> rdata=32'h0000_001F one cycle after the address is presented.
- Byte write 32'h1234_56AB to TIMER_CMP (WMASK=00111) after reset -> TIMER_CMP=32'hFFFF_FFAB; WMASK=00011 -> no change.
- BUTTONS[1] pulses high for DEBOUNCE_CYCLES-1 cycles -> BTN=0, BTN_EDGE=0. Held high for DEBOUNCE_CYCLES+2 cycles -> BTN=3'b010, BTN_EDGE=3'b010. W1C 3'b010 -> BTN_EDGE=0.
- W1C to BTN_EDGE on the same cycle as a new debounced edge -> bit remains 1.
- With MMIO_TIMER_EN: write TIMER=10 and TIMER_CMP=15 -> irq=1 six cycles after the TIMER write. W1C STATUS -> irq=0. Write TIMER=32'hFFFF_FFFF -> reads 0 two cycles later (wrap).
- Read with ADDR outside the window -> hit=0, rdata=0. Reset asserted mid-write -> leds stays 0.

Source files
------------

// File: rtl/mmio_responder_if.sv
// mmio_responder_if: CPU data-bus signals shared by RAM and the MMIO responder
interface mmio_responder_if;
   logic [31:0] ADDR;
   logic [31:0] WDATA;
   logic [4:0]  WMASK;
   logic [31:0] rdata;
   logic        hit;
   modport master (output ADDR, WDATA, WMASK, input rdata, hit);
   modport slave  (input ADDR, WDATA, WMASK, output rdata, hit);
endinterface

// File: rtl/mmio_responder.sv
// mmio_responder: LED, debounced buttons with sticky edges, optional timer (MMIO_TIMER_EN)
module mmio_responder #(
   parameter logic [31:0] BASE_ADDR       = 32'h0000_2000,
   parameter int          DEBOUNCE_CYCLES = 4,
   parameter int          NUM_LEDS        = 5
) (
   input  logic                CLK,
   input  logic                RESETN,
   mmio_responder_if.slave     bus,
   input  logic [2:0]          BUTTONS,
   output logic [NUM_LEDS-1:0] leds,
   output logic                irq
);
   localparam logic [4:0] M_BYTE = 5'b00111;
   localparam logic [4:0] M_HALF = 5'b01111;
   localparam logic [4:0] M_WORD = 5'b11111;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [4:0] m);
      return m == M_WORD ? wd : m == M_HALF ? {old[31:16], wd[15:0]} : {old[31:8], wd[7:0]};
   endfunction

   logic                hit, we;
   logic [5:0]          off;
   logic [31:0]         rd, led_w;
   logic [31:0]         rdata_q, rdata_d;
   logic [NUM_LEDS-1:0] leds_q, leds_d;
   logic [2:0]          sync1_q, sync2_q, btn_q, btn_d, btn_edge_q, btn_edge_d;
   logic [7:0]          cnt_q [3];
   logic [7:0]          cnt_d [3];
`ifdef MMIO_TIMER_EN
   logic [31:0]         timer_q, timer_d, cmp_q, cmp_d;
   logic                status_q, status_d;
`endif

   // decode, read mux, write merge and button debounce next-state
   always_comb begin
      hit     = bus.ADDR[31:8] == BASE_ADDR[31:8];
      off     = bus.ADDR[7:2];
      we      = hit && (bus.WMASK == M_BYTE || bus.WMASK == M_HALF || bus.WMASK == M_WORD);
      rd      = '0;
      case (off)
         6'd0: rd = 32'(leds_q);
         6'd1: rd = {29'b0, btn_q};
         6'd2: rd = {29'b0, btn_edge_q};
`ifdef MMIO_TIMER_EN
         6'd3: rd = timer_q;
         6'd4: rd = cmp_q;
         6'd5: rd = {31'b0, status_q};
`endif
         default: rd = '0;
      endcase
      rdata_d = hit ? rd : '0;
      led_w   = merge(32'(leds_q), bus.WDATA, bus.WMASK);
      leds_d  = (we && off == 6'd0) ? led_w[NUM_LEDS-1:0] : leds_q;
      btn_d   = btn_q;
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = (sync2_q[i] == btn_q[i] || cnt_q[i] == 8'(DEBOUNCE_CYCLES - 1)) ? 8'd0 : cnt_q[i] + 8'd1;
         btn_d[i] = (sync2_q[i] != btn_q[i] && cnt_q[i] == 8'(DEBOUNCE_CYCLES - 1)) ? sync2_q[i] : btn_q[i];
      end
      // a fresh rising edge overrides a simultaneous clear
      btn_edge_d = (btn_edge_q & ~((we && off == 6'd2) ? bus.WDATA[2:0] : 3'b0)) | (btn_d & ~btn_q);
   end

   // bus-facing, LED and button state registers
   always_ff @(posedge CLK or negedge RESETN)
      if (!RESETN) begin
         rdata_q    <= '0;
         leds_q     <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         btn_q      <= '0;
         btn_edge_q <= '0;
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      end else begin
         rdata_q    <= rdata_d;
         leds_q     <= leds_d;
         sync1_q    <= BUTTONS;
         sync2_q    <= sync1_q;
         btn_q      <= btn_d;
         btn_edge_q <= btn_edge_d;
         for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      end

`ifdef MMIO_TIMER_EN
   // timer counts unless written; a compare hit beats a simultaneous status clear
   always_comb begin
      timer_d  = (we && off == 6'd3) ? merge(timer_q, bus.WDATA, bus.WMASK) : timer_q + 32'd1;
      cmp_d    = (we && off == 6'd4) ? merge(cmp_q, bus.WDATA, bus.WMASK) : cmp_q;
      status_d = (timer_q == cmp_q) | (status_q & ~(we && off == 6'd5 && bus.WDATA[0]));
   end

   // timer, compare and status registers
   always_ff @(posedge CLK or negedge RESETN)
      if (!RESETN) begin
         timer_q  <= '0;
         cmp_q    <= 32'hFFFF_FFFF;
         status_q <= 1'b0;
      end else begin
         timer_q  <= timer_d;
         cmp_q    <= cmp_d;
         status_q <= status_d;
      end

   assign irq = status_q;
`else
   assign irq = 1'b0;
`endif

   assign bus.hit   = hit;
   assign bus.rdata = rdata_q;
   assign leds      = leds_q;
endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed plus random stimulus against a register-level model
module tb_mmio_responder;
   localparam int          DEB  = 4;
   localparam int          NL   = 5;
   localparam logic [31:0] BASE = 32'h0000_2000;
`ifdef MMIO_TIMER_EN
   localparam bit TMR = 1'b1;
`else
   localparam bit TMR = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RESETN = 1'b0;
   logic [2:0]    BUTTONS = '0;
   logic [NL-1:0] leds;
   logic          irq;
   int            n_tests = 0;
   int            n_fail = 0;

   mmio_responder_if bus();

   mmio_responder #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(DEB), .NUM_LEDS(NL)) dut (
      .CLK(CLK), .RESETN(RESETN), .bus(bus), .BUTTONS(BUTTONS), .leds(leds), .irq(irq));

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   logic [31:0] m_led, m_timer, m_cmp, m_rdata;
   logic [2:0]  m_s1, m_s2, m_db, m_edge;
   logic        m_status;
   int          m_run [3];

   task automatic model_reset();
      m_led = 0; m_timer = 0; m_cmp = 32'hFFFF_FFFF; m_rdata = 0;
      m_s1 = 0; m_s2 = 0; m_db = 0; m_edge = 0; m_status = 0;
      for (int b = 0; b < 3; b++) m_run[b] = 0;
   endtask

   function automatic logic [31:0] reg_read(input int o);
      case (o)
         0: return m_led;
         1: return {29'b0, m_db};
         2: return {29'b0, m_edge};
         3: return TMR ? m_timer : 32'd0;
         4: return TMR ? m_cmp : 32'd0;
         5: return TMR ? {31'b0, m_status} : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] apply(input logic [31:0] old, input logic [31:0] wd, input logic [4:0] m);
      logic [31:0] keep;
      keep = (m == 5'b00111) ? 32'hFFFF_FF00 : (m == 5'b01111) ? 32'hFFFF_0000 : 32'h0;
      return (old & keep) | (wd & ~keep);
   endfunction

   // one rising edge of the specified behaviour, from the currently applied inputs
   task automatic model_edge();
      logic        in_win, wr;
      int          o;
      logic [31:0] wd;
      logic [2:0]  n_db, clr;
      logic [31:0] n_led, n_timer, n_cmp;
      logic        n_status;
      in_win = bus.ADDR[31:8] == BASE[31:8];
      o      = int'(bus.ADDR[7:2]);
      wd     = bus.WDATA;
      wr     = in_win && (bus.WMASK == 5'b00111 || bus.WMASK == 5'b01111 || bus.WMASK == 5'b11111);
      m_rdata = in_win ? reg_read(o) : 32'd0;
      n_led = (wr && o == 0) ? apply(m_led, wd, bus.WMASK) & ((32'd1 << NL) - 32'd1) : m_led;
      n_db = m_db;
      for (int b = 0; b < 3; b++) begin
         if (m_s2[b] != m_db[b]) begin
            m_run[b]++;
            if (m_run[b] >= DEB) begin
               n_db[b] = m_s2[b];
               m_run[b] = 0;
            end
         end else m_run[b] = 0;
      end
      clr = (wr && o == 2) ? wd[2:0] : 3'b0;
      m_edge = (m_edge & ~clr) | (n_db & ~m_db);
      n_timer = m_timer; n_cmp = m_cmp; n_status = m_status;
      if (TMR) begin
         n_timer  = (wr && o == 3) ? apply(m_timer, wd, bus.WMASK) : m_timer + 1;
         n_cmp    = (wr && o == 4) ? apply(m_cmp, wd, bus.WMASK) : m_cmp;
         n_status = (m_timer == m_cmp) || (m_status && !(wr && o == 5 && wd[0]));
      end
      m_led = n_led; m_db = n_db; m_timer = n_timer; m_cmp = n_cmp; m_status = n_status;
      m_s2 = m_s1; m_s1 = BUTTONS;
   endtask

   task automatic tick();
      @(posedge CLK);
      if (RESETN) model_edge(); else model_reset();
      @(negedge CLK);
      check("rdata", bus.rdata, m_rdata);
      check("leds", 32'(leds), m_led);
      check("irq", 32'(irq), 32'(m_status));
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [4:0] m);
      bus.ADDR = a; bus.WDATA = d; bus.WMASK = m;
      #1 check("hit", 32'(bus.hit), 32'(a[31:8] == BASE[31:8]));
   endtask

   task automatic rd(input logic [7:0] o);
      drive(BASE + 32'(o), $urandom, 5'b00000);
   endtask

   logic [4:0] masks [6] = '{5'b00111, 5'b01111, 5'b11111, 5'b00011, 5'b00000, 5'b10111};

   initial begin
      bit found;
      logic [31:0] a;
      model_reset();
      drive(32'h0, 0, 0);
      repeat (2) tick();
      check("rst_rdata", bus.rdata, 0);
      check("rst_leds", 32'(leds), 0);
      RESETN = 1'b1;
      rd(8'h10); tick(); tick();
      check("rst_cmp", bus.rdata, TMR ? 32'hFFFF_FFFF : 32'h0);

      drive(BASE, 32'hFFFF_FFFF, 5'b11111); tick();
      check("led_word", 32'(leds), 32'h1F);
      rd(8'h00); tick();
      check("led_read", bus.rdata, 32'h0000_001F);

      drive(BASE + 32'h10, 32'h1234_56AB, 5'b00111); tick();
      drive(BASE + 32'h10, 32'hDEAD_BEEF, 5'b00011); tick();
      rd(8'h10); tick(); tick();
      check("cmp_byte", bus.rdata, TMR ? 32'hFFFF_FFAB : 32'h0);

      BUTTONS = 3'b010;
      rd(8'h04);
      repeat (DEB - 1) tick();
      BUTTONS = 3'b000;
      repeat (DEB + 4) tick();
      check("btn_pulse", bus.rdata, 0);
      rd(8'h08); tick();
      check("edge_pulse", bus.rdata, 0);
      BUTTONS = 3'b010;
      drive(32'h0, 0, 0);
      repeat (DEB + 2) tick();
      rd(8'h04); tick();
      check("btn_held", bus.rdata, 32'h2);
      rd(8'h08); tick();
      check("edge_held", bus.rdata, 32'h2);
      drive(BASE + 32'h08, 32'h2, 5'b11111); tick();
      rd(8'h08); tick(); tick();
      check("edge_w1c", bus.rdata, 0);

      BUTTONS = 3'b000;
      drive(32'h0, 0, 0);
      repeat (DEB + 4) tick();
      BUTTONS = 3'b001;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (m_s2[0] != m_db[0] && m_run[0] == DEB - 1) found = 1;
         else tick();
      end
      check("race_found", 32'(found), 1);
      drive(BASE + 32'h08, 32'h1, 5'b11111); tick();
      rd(8'h08); tick(); tick();
      check("edge_race", 32'(bus.rdata[0]), 1);

`ifdef MMIO_TIMER_EN
      drive(BASE + 32'h10, 15, 5'b11111); tick();
      drive(BASE + 32'h0C, 10, 5'b11111); tick();
      drive(32'h0, 0, 0);
      repeat (5) begin
         tick();
         check("irq_early", 32'(irq), 0);
      end
      tick();
      check("irq_set", 32'(irq), 1);
      drive(BASE + 32'h14, 1, 5'b11111); tick();
      check("irq_clr", 32'(irq), 0);
      drive(BASE + 32'h0C, 32'hFFFF_FFFF, 5'b11111); tick();
      drive(32'h0, 0, 0); tick();
      rd(8'h0C); tick();
      check("timer_wrap", bus.rdata, 0);
`endif

      drive(32'h0000_3004, 0, 0); tick();
      check("outside", bus.rdata, 0);

      drive(BASE, 32'h15, 5'b11111);
      #2 RESETN = 1'b0;
      tick();
      RESETN = 1'b1;
      drive(32'h0, 0, 0); tick();
      check("rst_midwrite", 32'(leds), 0);

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) BUTTONS[$urandom_range(0, 2)] ^= 1'b1;
         a = ($urandom_range(0, 9) == 0) ? $urandom : BASE + 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
         drive(a, $urandom, masks[$urandom_range(0, 5)]);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
